// File: rtl/cpu_mem_responder_if.sv
// CPU-side native fetch and data request bus seen by the behavioural memory responder.
// master = CPU core, slave = responder.
interface cpu_mem_responder_if;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;

    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    modport master (
        output PC, Inst_Req_Valid, Inst_Ready,
        output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        input  Inst_Req_Ready, Instruction, Inst_Valid,
        input  Mem_Req_Ready, Read_data, Read_data_Valid
    );

    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ready,
        input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
        output Inst_Req_Ready, Instruction, Inst_Valid,
        output Mem_Req_Ready, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Behavioural fetch/load/store responder over one shared word RAM, with
// handshake acceptance and response latency stretched by an external stall mask.
module cpu_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter bit          STALL_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              random_mask,
    cpu_mem_responder_if.slave      bus,
    output logic                    err,
    output logic [31:0]             inst_cnt,
    output logic [31:0]             load_cnt,
    output logic [31:0]             store_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_RESP} fetch_state_t;
    typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RESP} data_state_t;

    logic [31:0] mem [DEPTH];

    logic [3:0]            mask;
    fetch_state_t          i_state, i_next;
    data_state_t           d_state, d_next;

    logic                  inst_req_ready, inst_valid;
    logic                  mem_req_ready, rd_valid;
    logic                  fetch_fire, inst_done;
    logic                  st_fire, ld_fire, ld_done;
    logic                  pc_ok, addr_ok;
    logic [ADDR_WIDTH-1:0] pc_idx, addr_idx;
    logic [31:0]           instr_q, rdata_q;

    // Byte offsets and the reserved mask bit carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{random_mask[4], bus.PC[1:0], bus.Address[1:0]};

    assign mask = STALL_EN ? random_mask[3:0] : '0;

    assign pc_ok    = (bus.PC >> (ADDR_WIDTH + 2)) == 32'd0;
    assign addr_ok  = (bus.Address >> (ADDR_WIDTH + 2)) == 32'd0;
    assign pc_idx   = bus.PC[ADDR_WIDTH+1:2];
    assign addr_idx = bus.Address[ADDR_WIDTH+1:2];

    assign fetch_fire = bus.Inst_Req_Valid & inst_req_ready;
    assign inst_done  = inst_valid & bus.Inst_Ready;
    assign st_fire    = bus.MemWrite & mem_req_ready;
    assign ld_fire    = bus.MemRead & ~bus.MemWrite & mem_req_ready;
    assign ld_done    = rd_valid & bus.Read_data_Ready;

    // ---------------- fetch FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) i_state <= I_IDLE;
        else     i_state <= i_next;
    end

    always_comb begin
        i_next = i_state;
        unique case (i_state)
            I_IDLE:  if (fetch_fire)     i_next = I_WAIT;
            I_WAIT:  if (!mask[1])       i_next = I_RESP;
            I_RESP:  if (bus.Inst_Ready) i_next = I_IDLE;
            default:                     i_next = I_IDLE;
        endcase
    end

    always_comb begin
        inst_req_ready = 1'b0;
        inst_valid     = 1'b0;
        unique case (i_state)
            I_IDLE:  inst_req_ready = ~mask[0] & ~rst;
            I_RESP:  inst_valid     = 1'b1;
            default: ;
        endcase
    end

    // ---------------- data FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) d_state <= D_IDLE;
        else     d_state <= d_next;
    end

    always_comb begin
        d_next = d_state;
        unique case (d_state)
            D_IDLE:  if (ld_fire)             d_next = D_WAIT;
            D_WAIT:  if (!mask[3])            d_next = D_RESP;
            D_RESP:  if (bus.Read_data_Ready) d_next = D_IDLE;
            default:                          d_next = D_IDLE;
        endcase
    end

    always_comb begin
        mem_req_ready = 1'b0;
        rd_valid      = 1'b0;
        unique case (d_state)
            D_IDLE:  mem_req_ready = ~mask[2] & ~rst;
            D_RESP:  rd_valid      = 1'b1;
            default: ;
        endcase
    end

    assign bus.Inst_Req_Ready  = inst_req_ready;
    assign bus.Inst_Valid      = inst_valid;
    assign bus.Instruction     = instr_q;
    assign bus.Mem_Req_Ready   = mem_req_ready;
    assign bus.Read_data_Valid = rd_valid;
    assign bus.Read_data       = rdata_q;

    // ---------------- shared RAM ----------------
    // RAM is never reset; captures use the pre-edge word so a same-edge store is not seen.
    always_ff @(posedge clk) begin
        if (!rst && st_fire && addr_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.Write_strb[i]) mem[addr_idx][8*i +: 8] <= bus.Write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            rdata_q <= '0;
        end else begin
            if (fetch_fire) instr_q <= pc_ok ? mem[pc_idx] : '0;
            if (ld_fire)    rdata_q <= addr_ok ? mem[addr_idx] : '0;
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err       <= 1'b0;
            inst_cnt  <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if ((fetch_fire && !pc_ok) || (ld_fire && !addr_ok) ||
                (st_fire && (!addr_ok || bus.MemRead)))
                err <= 1'b1;
            if (inst_done) inst_cnt  <= inst_cnt + 32'd1;
            if (ld_done)   load_cnt  <= load_cnt + 32'd1;
            if (st_fire)   store_cnt <= store_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: directed requests push expected
// responses; negedge monitors check data, latency and hold behaviour.
module tb_cpu_mem_responder;

    localparam int unsigned AW = 10;
    localparam logic [31:0] OOR = 32'(1) << (AW + 2);

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  random_mask;
    logic        err;
    logic [31:0] inst_cnt, load_cnt, store_cnt;

    cpu_mem_responder_if bus();

    cpu_mem_responder #(.ADDR_WIDTH(AW), .STALL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .random_mask(random_mask), .bus(bus),
        .err(err), .inst_cnt(inst_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } resp_t;

    resp_t iq[$];
    resp_t lq[$];
    int    i_acc = 0, l_acc = 0;
    int    total = 0, bad = 0;
    int    exp_i = 0, exp_l = 0, exp_s = 0;
    logic  exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors ----------------
    logic iv_q = 1'b0, lv_q = 1'b0;

    always @(negedge clk) begin
        if (bus.Inst_Valid && !iv_q) begin
            if (iq.size() == 0) check("inst_unexpected_valid", 32'(bus.Inst_Valid), 32'd0);
            else check("inst_latency", cyc - i_acc, iq[0].lat);
        end
        if (bus.Inst_Valid && iq.size() > 0) begin
            if (bus.Inst_Ready) begin
                check("inst_data", bus.Instruction, iq[0].data);
                void'(iq.pop_front());
                exp_i++;
            end else begin
                check("inst_hold", bus.Instruction, iq[0].data);
            end
        end
        iv_q = bus.Inst_Valid;
    end

    always @(negedge clk) begin
        if (bus.Read_data_Valid && !lv_q) begin
            if (lq.size() == 0) check("load_unexpected_valid", 32'(bus.Read_data_Valid), 32'd0);
            else check("load_latency", cyc - l_acc, lq[0].lat);
        end
        if (bus.Read_data_Valid && lq.size() > 0) begin
            if (bus.Read_data_Ready) begin
                check("load_data", bus.Read_data, lq[0].data);
                void'(lq.pop_front());
                exp_l++;
            end else begin
                check("load_hold", bus.Read_data, lq[0].data);
            end
        end
        lv_q = bus.Read_data_Valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic fetch_start(input logic [31:0] pc, input logic [31:0] exp, input int lat);
        bit ok = 0;
        bus.PC = pc;
        bus.Inst_Req_Valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.Inst_Req_Ready) begin
                iq.push_back('{exp, lat});
                if ((pc >> (AW + 2)) != 0) exp_err = 1'b1;
                @(posedge clk); #1;
                i_acc = cyc;
                ok = 1;
            end
        end
        if (!ok) check("fetch_accept_timeout", 32'(bus.Inst_Req_Ready), 32'd1);
        bus.Inst_Req_Valid = 1'b0;
    endtask

    task automatic load_start(input logic [31:0] addr, input logic [31:0] exp, input int lat);
        bit ok = 0;
        bus.Address = addr;
        bus.MemRead = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.Mem_Req_Ready) begin
                lq.push_back('{exp, lat});
                if ((addr >> (AW + 2)) != 0) exp_err = 1'b1;
                @(posedge clk); #1;
                l_acc = cyc;
                ok = 1;
            end
        end
        if (!ok) check("load_accept_timeout", 32'(bus.Mem_Req_Ready), 32'd1);
        bus.MemRead = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic with_read);
        bit ok = 0;
        bus.Address    = addr;
        bus.Write_data = data;
        bus.Write_strb = strb;
        bus.MemWrite   = 1'b1;
        bus.MemRead    = with_read;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.Mem_Req_Ready) begin
                exp_s++;
                if (with_read || (addr >> (AW + 2)) != 0) exp_err = 1'b1;
                @(posedge clk); #1;
                ok = 1;
            end
        end
        if (!ok) check("store_accept_timeout", 32'(bus.Mem_Req_Ready), 32'd1);
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (iq.size() > 0 || lq.size() > 0); k++) @(posedge clk);
        #1;
        if (iq.size() > 0 || lq.size() > 0) begin
            check("drain_timeout", 32'(iq.size() + lq.size()), 32'd0);
            iq.delete();
            lq.delete();
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_inst_cnt"},  inst_cnt,  exp_i);
        check({tag, "_load_cnt"},  load_cnt,  exp_l);
        check({tag, "_store_cnt"}, store_cnt, exp_s);
        check({tag, "_err"},       32'(err),  32'(exp_err));
    endtask

    task automatic wait_load_valid();
        bit seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (bus.Read_data_Valid) seen = 1;
        end
        if (!seen) check("load_valid_timeout", 32'(bus.Read_data_Valid), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        random_mask = '0;
        bus.PC = '0; bus.Inst_Req_Valid = 1'b0; bus.Inst_Ready = 1'b1;
        bus.Address = '0; bus.MemWrite = 1'b0; bus.Write_data = '0; bus.Write_strb = '0;
        bus.MemRead = 1'b0; bus.Read_data_Ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inst_req_ready", 32'(bus.Inst_Req_Ready), 32'd0);
        check("rst_mem_req_ready",  32'(bus.Mem_Req_Ready),  32'd0);
        check("rst_inst_valid",     32'(bus.Inst_Valid),     32'd0);
        check("rst_instruction",    bus.Instruction,         32'd0);
        check("rst_rd_valid",       32'(bus.Read_data_Valid), 32'd0);
        check("rst_read_data",      bus.Read_data,           32'd0);
        check_counters("rst");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_inst_req_ready", 32'(bus.Inst_Req_Ready), 32'd1);
        check("idle_mem_req_ready",  32'(bus.Mem_Req_Ready),  32'd1);
        @(posedge clk); #1;

        // basic fetch
        store(32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
        fetch_start(32'h40, 32'hDEADBEEF, 1);
        drain();
        check_counters("fetch1");

        // byte-lane store merge; reserved mask bit must not stall anything
        random_mask = 5'b10000;
        store(32'h80, 32'hAAAAAAAA, 4'hF, 1'b0);
        store(32'h80, 32'h11223344, 4'b0101, 1'b0);
        load_start(32'h80, 32'hAA22AA44, 1);
        drain();
        check_counters("strb");
        random_mask = '0;

        // fetch held off by mask[0], then response stalled two cycles by mask[1]
        random_mask = 5'b00001;
        bus.PC = 32'h80;
        bus.Inst_Req_Valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("fetch_masked_ready", 32'(bus.Inst_Req_Ready), 32'd0);
            @(posedge clk); #1;
        end
        check("fetch_masked_no_valid", 32'(bus.Inst_Valid), 32'd0);
        random_mask = '0;
        fetch_start(32'h80, 32'hAA22AA44, 3);
        random_mask = 5'b00010;
        repeat (2) @(posedge clk);
        #1 random_mask = '0;
        drain();
        check_counters("fetch_stall");

        // load stalled 4 cycles, then held 3 cycles with Ready low
        bus.Read_data_Ready = 1'b0;
        load_start(32'h40, 32'hDEADBEEF, 5);
        random_mask = 5'b01000;
        repeat (4) @(posedge clk);
        #1 random_mask = '0;
        wait_load_valid();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("load_hold_valid", 32'(bus.Read_data_Valid), 32'd1);
        end
        @(posedge clk); #1 bus.Read_data_Ready = 1'b1;
        drain();
        check_counters("load_stall");

        // out-of-range accesses alias in-range words if the range check is missing
        load_start(OOR | 32'h40, 32'h0, 1);
        drain();
        check_counters("oor_load");
        fetch_start(OOR | 32'h40, 32'h0, 1);
        drain();
        store(32'h100, 32'h55667788, 4'hF, 1'b1);
        store(OOR | 32'h100, 32'h0BADBAD0, 4'hF, 1'b0);
        load_start(32'h100, 32'h55667788, 1);
        drain();
        check_counters("oor_store");

        // same-edge fetch and store to word 5
        store(32'h14, 32'h01010101, 4'hF, 1'b0);
        fork
            fetch_start(32'h14, 32'h01010101, 1);
            store(32'h14, 32'h0F0F0F0F, 4'hF, 1'b0);
        join
        drain();
        load_start(32'h14, 32'h0F0F0F0F, 1);
        drain();
        check_counters("same_edge");

        // reset while a load response is pending, with a store presented on the reset edge
        bus.Read_data_Ready = 1'b0;
        load_start(32'h80, 32'hAA22AA44, 1);
        wait_load_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        lq.delete();
        bus.Address = 32'h100; bus.Write_data = 32'hFFFFFFFF; bus.Write_strb = 4'hF;
        bus.MemWrite = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_req_ready", 32'(bus.Mem_Req_Ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.MemWrite = 1'b0;
        random_mask = 5'b00100;
        exp_i = 0; exp_l = 0; exp_s = 0; exp_err = 1'b0;
        @(negedge clk);
        check("rst_mid_rd_valid", 32'(bus.Read_data_Valid), 32'd0);
        check("rst_mid_read_data", bus.Read_data, 32'd0);
        check("rst_mid_masked_ready", 32'(bus.Mem_Req_Ready), 32'd0);
        check_counters("rst_mid");
        @(posedge clk); #1 random_mask = '0;
        bus.Read_data_Ready = 1'b1;
        @(negedge clk);
        check("rst_mid_ready_back", 32'(bus.Mem_Req_Ready), 32'd1);
        @(posedge clk); #1;
        load_start(32'h100, 32'h55667788, 1);
        drain();
        check_counters("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Behavioural responder for the custom CPU's native instruction and data request interfaces. It lets the core be simulated without the inst/mem interface wrappers, the AXI arbiter or the AXI RAM: it accepts fetch, load and store requests directly and answers from one shared word-addressed RAM. Handshake acceptance and response latency are stretched by an externally supplied pseudo-random mask, so the core's handshakes are exercised under realistic stalls.

## Interface

Parameters:
- ADDR_WIDTH, 14, RAM word-index width; RAM holds 2^ADDR_WIDTH 32-bit words.
- STALL_EN, 1, when 0 the random_mask input is ignored and treated as all zeros.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- random_mask  in  5  stall control: [0] fetch accept, [1] fetch response, [2] data accept, [3] load response, [4] reserved and ignored.
- PC  in  32  fetch byte address.
- Inst_Req_Valid  in  1  fetch request valid.
- Inst_Req_Ready  out  1  fetch request accepted this cycle.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  Instruction valid.
- Inst_Ready  in  1  CPU consumes Instruction.
- Address  in  32  data byte address.
- MemWrite  in  1  store request.
- Write_data  in  32  store data.
- Write_strb  in  4  store byte enables; bit i enables byte lane i.
- MemRead  in  1  load request.
- Mem_Req_Ready  out  1  data request accepted this cycle.
- Read_data  out  32  load data.
- Read_data_Valid  out  1  Read_data valid.
- Read_data_Ready  in  1  CPU consumes Read_data.
- err  out  1  sticky protocol/range error flag.
- inst_cnt, load_cnt, store_cnt  out  32 each  completed fetch / load / store counts.

## Operation

- There are two independent FSMs, fetch and data. Both share the RAM. RAM contents are never reset.
- Word index is addr[ADDR_WIDTH+1:2]; addr[1:0] is ignored.
- An address is out of range when addr[31:ADDR_WIDTH+2] != 0.
  - Out-of-range fetches and loads return 32'h0 and set err.
  - Out-of-range stores are dropped and set err.
- Fetch FSM, states I_IDLE, I_WAIT, I_RESP:
  - Inst_Req_Ready = (I_IDLE) & ~mask[0].
  - On Inst_Req_Valid & Inst_Req_Ready, capture RAM[PC] into the Instruction register and go to I_WAIT.
  - I_WAIT goes to I_RESP on the first cycle with ~mask[1].
  - In I_RESP, Inst_Valid=1. On Inst_Ready, go to I_IDLE and increment inst_cnt.
- Data FSM, states D_IDLE, D_WAIT, D_RESP:
  - Mem_Req_Ready = (D_IDLE) & ~mask[2].
  - Accepted store (MemWrite & Mem_Req_Ready): write the enabled byte lanes at that edge, stay in D_IDLE, increment store_cnt. There is no write response.
  - Accepted load (MemRead & ~MemWrite & Mem_Req_Ready): capture RAM word into the Read_data register and go to D_WAIT.
  - D_WAIT goes to D_RESP on the first cycle with ~mask[3].
  - In D_RESP, Read_data_Valid=1. On Read_data_Ready, go to D_IDLE and increment load_cnt.
  - MemRead & MemWrite together at acceptance: executed as a store; err set.
- Same-edge fetch capture and store to the same word: the fetch returns the old word (read-before-write).
- Instruction and Read_data hold their values from capture until the next capture.
- Counters wrap modulo 2^32.

## Timing

- Reset values:
  - Inst_Req_Ready=0, Inst_Valid=0, Instruction=0.
  - Mem_Req_Ready=0, Read_data_Valid=0, Read_data=0.
  - err=0, all counters=0.
  - Both FSMs in IDLE.
- Ready outputs are combinational from state and mask. They are forced 0 while rst=1.
- Minimum fetch/load latency: request accepted at edge T; WAIT during cycle T+1; Valid asserted in cycle T+2 if mask[1]/mask[3]=0 in cycle T+1.
  - Each masked WAIT cycle adds one cycle.
- Valid, once high, stays high with stable data until the consume handshake. The mask never drops it.
- After a consume at edge R, the port is IDLE in cycle R+1, so Ready can reassert there.
  - Peak throughput is one fetch or load per 3 cycles, and one store per cycle.
- A request present while Ready=0 is not accepted and causes no side effect.
- Reset mid-operation: rst wins over every same-edge event.
  - A pending response is dropped and a store on the reset edge is not written.
  - err and counters clear; the FSMs return to IDLE next cycle.

## Test plan

- Preload RAM[0x10]=0xDEADBEEF, STALL_EN=0; fetch PC=0x40, Inst_Ready=1 -> Instruction=0xDEADBEEF with Inst_Valid in cycle T+2; inst_cnt=1.
- Store 0x11223344 with strb=4'b0101 to 0x80 over word 0xAAAAAAAA, then load 0x80 -> Read_data=0xAA22AA44; store_cnt=1, load_cnt=1.
- mask[3]=1 for 4 cycles after load accept, Read_data_Ready=0 for 3 extra cycles -> Read_data_Valid first high at T+6, stays high with stable data until consume.
- Load from address 1<<(ADDR_WIDTH+2) -> Read_data=0, err=1. Then MemRead&MemWrite together -> executed as a store; err stays 1.
- Same-edge fetch of word 5 and store to word 5 -> Instruction = old word, RAM = new word.
- Assert rst in D_RESP with Read_data_Valid=1 -> next cycle Read_data_Valid=0, counters=0, err=0, Mem_Req_Ready follows ~mask[2] after rst drops.
